// File: rtl/hvac_pkg.sv
// Shared types for the HVAC actuator sequencer: FSM states, demand codes
// and the raw demand decode used by the debouncer.
package hvac_pkg;

  localparam int DMD_W    = 12;
  localparam int STARTS_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEAT    = 2'd1,
    ST_COOL    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_HEAT = 2'd1,
    REQ_COOL = 2'd2
  } req_t;

  // Conflicting demand (both words nonzero) is treated as no demand.
  function automatic req_t decode_req(input logic [DMD_W-1:0] hon,
                                      input logic [DMD_W-1:0] con);
    if ((|hon) && !(|con))      return REQ_HEAT;
    else if ((|con) && !(|hon)) return REQ_COOL;
    else                        return REQ_NONE;
  endfunction

endpackage

// File: rtl/hvac_req_debounce.sv
// Raw demand decode plus stability filter; the filtered code only follows a
// raw code that has been held for DEB consecutive cycles.
module hvac_req_debounce
  import hvac_pkg::*;
#(
  parameter int DEB   = 4,
  parameter int TMR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DMD_W-1:0] Hon,
  input  logic [DMD_W-1:0] Con,
  output req_t             filt
);

  localparam logic [TMR_W-1:0] DEB_TC  = TMR_W'(DEB - 1);
  localparam logic [TMR_W-1:0] CNT_MAX = '1;

  req_t             raw;
  req_t             cand;
  logic [TMR_W-1:0] cnt;
  logic [TMR_W-1:0] cnt_nxt;

  // Using the post-edge count lets DEB=1 accept a new code on its first edge.
  always_comb begin
    raw     = decode_req(Hon, Con);
    cnt_nxt = cnt;
    if (raw != cand)         cnt_nxt = '0;
    else if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand <= REQ_NONE;
      cnt  <= '0;
      filt <= REQ_NONE;
    end else begin
      cand <= raw;
      cnt  <= cnt_nxt;
      if (cnt_nxt == DEB_TC) filt <= raw;
    end
  end

endmodule

// File: rtl/hvac_actuator_seq.sv
// Heater/cooler sequencer: debounced demand, minimum-on and lockout timing,
// mutually exclusive enables and a saturating start counter.
//   state   | meaning
//   IDLE    | both enables off, waiting for filtered demand
//   HEAT    | heater on, held for at least MIN_ON cycles
//   COOL    | cooler on, held for at least MIN_ON cycles
//   LOCKOUT | both off for MIN_OFF cycles, demand ignored
module hvac_actuator_seq
  import hvac_pkg::*;
#(
  parameter int DEB     = 4,
  parameter int MIN_ON  = 16,
  parameter int MIN_OFF = 8,
  parameter int TMR_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DMD_W-1:0]    Hon,
  input  logic [DMD_W-1:0]    Con,
  output logic                heat_en,
  output logic                cool_en,
  output logic [1:0]          state,
  output logic [STARTS_W-1:0] starts
);

  localparam logic [TMR_W-1:0]    ON_TC      = TMR_W'(MIN_ON - 1);
  localparam logic [TMR_W-1:0]    OFF_TC     = TMR_W'(MIN_OFF - 1);
  localparam logic [TMR_W-1:0]    TMR_MAX    = '1;
  localparam logic [STARTS_W-1:0] STARTS_MAX = '1;

  req_t                filt;
  state_t              st;
  logic [TMR_W-1:0]    tmr;
  logic [TMR_W-1:0]    tmr_inc;
  logic [STARTS_W-1:0] starts_inc;

  hvac_req_debounce #(
    .DEB   (DEB),
    .TMR_W (TMR_W)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .Hon   (Hon),
    .Con   (Con),
    .filt  (filt)
  );

  assign tmr_inc    = (tmr == TMR_MAX) ? tmr : tmr + 1'b1;
  assign starts_inc = (starts == STARTS_MAX) ? starts : starts + 1'b1;
  assign state      = st;

  // Enables are registered alongside the state so they are a pure decode of it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st      <= ST_IDLE;
      tmr     <= '0;
      heat_en <= 1'b0;
      cool_en <= 1'b0;
      starts  <= '0;
    end else begin
      tmr <= tmr_inc;
      case (st)
        ST_IDLE: begin
          if (filt == REQ_HEAT) begin
            st      <= ST_HEAT;
            tmr     <= '0;
            heat_en <= 1'b1;
            starts  <= starts_inc;
          end else if (filt == REQ_COOL) begin
            st      <= ST_COOL;
            tmr     <= '0;
            cool_en <= 1'b1;
            starts  <= starts_inc;
          end
        end
        ST_HEAT: begin
          if (filt != REQ_HEAT && tmr >= ON_TC) begin
            st      <= ST_LOCKOUT;
            tmr     <= '0;
            heat_en <= 1'b0;
          end
        end
        ST_COOL: begin
          if (filt != REQ_COOL && tmr >= ON_TC) begin
            st      <= ST_LOCKOUT;
            tmr     <= '0;
            cool_en <= 1'b0;
          end
        end
        ST_LOCKOUT: begin
          if (tmr == OFF_TC) begin
            st  <= ST_IDLE;
            tmr <= '0;
          end
        end
        default: begin
          st      <= ST_IDLE;
          tmr     <= '0;
          heat_en <= 1'b0;
          cool_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hvac_actuator_seq.sv
// Bench for hvac_actuator_seq: directed scenarios plus random demand segments,
// compared each cycle against a run-length behavioural model and timing properties.
module tb_hvac_actuator_seq;

  localparam int DEB     = 4;
  localparam int MIN_ON  = 16;
  localparam int MIN_OFF = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] Hon;
  logic [11:0] Con;
  logic        heat_en;
  logic        cool_en;
  logic [1:0]  state;
  logic [15:0] starts;

  always #5 clk = ~clk;

  hvac_actuator_seq #(
    .DEB     (DEB),
    .MIN_ON  (MIN_ON),
    .MIN_OFF (MIN_OFF),
    .TMR_W   (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Hon     (Hon),
    .Con     (Con),
    .heat_en (heat_en),
    .cool_en (cool_en),
    .state   (state),
    .starts  (starts)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: 0 idle, 1 heat, 2 cool, 3 lockout; demand codes 0 none, 1 heat, 2 cool.
  int m_state  = 0;
  int m_in     = 0;
  int m_starts = 0;
  int m_filt   = 0;
  int m_last   = 0;
  int m_run    = 1;

  task automatic model_step(input bit r, input logic [11:0] h, input logic [11:0] c);
    int raw;
    int nst;
    raw = (h != 0 && c == 0) ? 1 : (c != 0 && h == 0) ? 2 : 0;
    if (!r) begin
      m_state = 0; m_in = 0; m_starts = 0;
      m_filt = 0; m_last = 0; m_run = 1;
      return;
    end
    nst = m_state;
    if (m_state == 0 && m_filt != 0) nst = m_filt;
    else if ((m_state == 1 || m_state == 2) && m_filt != m_state && m_in + 1 >= MIN_ON) nst = 3;
    else if (m_state == 3 && m_in + 1 == MIN_OFF) nst = 0;
    if (m_state == 0 && nst != 0 && m_starts < 65535) m_starts++;
    m_in = (nst != m_state) ? 0 : m_in + 1;
    m_state = nst;
    // Filtered code follows a raw code on the edge where it has been seen DEB times in a row.
    if (raw == m_last) m_run++;
    else begin
      m_last = raw;
      m_run  = 1;
    end
    if (m_run == DEB) m_filt = raw;
  endtask

  bit prev_en   = 1'b0;
  bit have_drop = 1'b0;
  int on_run    = 0;
  int off_run   = 0;

  task automatic prop_update(input bit r);
    bit en;
    en = heat_en | cool_en;
    if (!r) begin
      prev_en = 1'b0; have_drop = 1'b0; on_run = 0; off_run = 0;
      return;
    end
    if (en) begin
      if (!prev_en && have_drop) chk("min_off", 32'(off_run >= MIN_OFF + 1), 32'd1);
      on_run++;
    end else begin
      if (prev_en) begin
        chk("min_on", 32'(on_run >= MIN_ON), 32'd1);
        have_drop = 1'b1;
        off_run   = 0;
        on_run    = 0;
      end
      off_run++;
    end
    prev_en = en;
  endtask

  task automatic step(input bit r, input logic [11:0] h, input logic [11:0] c);
    rst_n = r;
    Hon   = h;
    Con   = c;
    model_step(r, h, c);
    @(negedge clk);
    chk("state",   32'(state),   32'(m_state));
    chk("heat_en", 32'(heat_en), 32'(m_state == 1));
    chk("cool_en", 32'(cool_en), 32'(m_state == 2));
    chk("starts",  32'(starts),  32'(m_starts));
    chk("excl",    32'(heat_en & cool_en), 32'd0);
    prop_update(r);
  endtask

  initial begin
    int on_cnt;
    int lock_cnt;
    logic [11:0] h;
    logic [11:0] c;
    bit r;
    int len;

    rst_n = 1'b0;
    Hon   = '0;
    Con   = '0;

    // Reset and heat rise after edge DEB+1
    step(0, 12'h000, 12'h000);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_starts", 32'(starts), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      step(1, 12'h001, 12'h000);
      if (i == 4) chk("s1_pre_rise", 32'(heat_en), 32'd0);
    end
    chk("s1_heat_en", 32'(heat_en), 32'd1);
    chk("s1_cool_en", 32'(cool_en), 32'd0);
    chk("s1_starts", 32'(starts), 32'd1);

    // Short heating demand: minimum-on then lockout
    repeat (4) step(1, 12'h001, 12'h000);
    on_cnt   = 5;
    lock_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 12'h000, 12'h000);
      if (heat_en) on_cnt++;
      if (state == 2'd3) lock_cnt++;
      if (lock_cnt > 0 && state == 2'd0) break;
    end
    chk("s2_on_cycles", 32'(on_cnt), 32'd16);
    chk("s2_lock_cycles", 32'(lock_cnt), 32'd8);
    chk("s2_idle", 32'(state), 32'd0);

    // Cool glitch shorter than DEB
    step(0, 12'h000, 12'h000);
    repeat (3) step(1, 12'h000, 12'h001);
    repeat (10) step(1, 12'h000, 12'h000);
    chk("s3_state", 32'(state), 32'd0);
    chk("s3_starts", 32'(starts), 32'd0);

    // HEAT to COOL through lockout, then reset while cooling
    step(0, 12'h000, 12'h000);
    repeat (25) step(1, 12'h001, 12'h000);
    lock_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      step(1, 12'h000, 12'h001);
      if (state == 2'd3) lock_cnt++;
      if (state == 2'd2) break;
    end
    chk("s4_state", 32'(state), 32'd2);
    chk("s4_lock_cycles", 32'(lock_cnt), 32'd8);
    chk("s4_starts", 32'(starts), 32'd2);
    step(0, 12'h000, 12'h001);
    chk("s6_state", 32'(state), 32'd0);
    chk("s6_cool_en", 32'(cool_en), 32'd0);
    chk("s6_starts", 32'(starts), 32'd0);

    // Conflicting demand
    step(0, 12'h000, 12'h000);
    repeat (20) step(1, 12'h001, 12'h001);
    chk("s5_state", 32'(state), 32'd0);
    chk("s5_heat_en", 32'(heat_en), 32'd0);
    chk("s5_cool_en", 32'(cool_en), 32'd0);

    // Random demand segments, mixing sub-DEB glitches with long holds
    for (int s = 0; s < 150; s++) begin
      r = ($urandom_range(0, 29) != 0);
      h = ($urandom_range(0, 1) != 0) ? 12'($urandom_range(1, 4095)) : 12'h000;
      c = ($urandom_range(0, 1) != 0) ? 12'($urandom_range(1, 4095)) : 12'h000;
      len = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, DEB - 1))
                                        : int'($urandom_range(DEB, 40));
      if (!r) step(0, h, c);
      else for (int k = 0; k < len; k++) step(1, h, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
